// File: rtl/cosim_trace_queue.sv
// Commit/trap trace queue between the core commit stage and the co-simulation
// checker. Each cycle up to COMMIT_WIDTH retired instructions plus one optional
// trap record are compacted in program order into a DEPTH-entry ring buffer and
// presented one record per cycle on a valid/ready port.
module cosim_trace_queue #(
   parameter int COMMIT_WIDTH = 3,
   parameter int XLEN         = 64,
   parameter int INST_LEN     = 32,
   parameter int DEPTH        = 16
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [COMMIT_WIDTH-1:0]          valid,
   input  logic [XLEN-1:0]                  hartid,
   input  logic [XLEN*COMMIT_WIDTH-1:0]     pc,
   input  logic [INST_LEN*COMMIT_WIDTH-1:0] inst,
   input  logic [XLEN*COMMIT_WIDTH-1:0]     wdata,
   input  logic [XLEN*COMMIT_WIDTH-1:0]     mstatus,
   input  logic [COMMIT_WIDTH-1:0]          check,
   input  logic                             int_xcpt,
   input  logic [XLEN-1:0]                  cause,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic                             out_is_trap,
   output logic [XLEN-1:0]                  out_hartid,
   output logic [XLEN-1:0]                  out_pc,
   output logic [INST_LEN-1:0]              out_inst,
   output logic [XLEN-1:0]                  out_wdata,
   output logic [XLEN-1:0]                  out_mstatus,
   output logic                             out_check,
   output logic [XLEN-1:0]                  out_cause,
   output logic                             stall,
   output logic                             overflow,
   output logic [$clog2(DEPTH+1)-1:0]       count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   // Entry storage; never reset, only the pointers define what is live.
   logic                is_trap_mem [DEPTH];
   logic [XLEN-1:0]     hartid_mem  [DEPTH];
   logic [XLEN-1:0]     pc_mem      [DEPTH];
   logic [INST_LEN-1:0] inst_mem    [DEPTH];
   logic [XLEN-1:0]     wdata_mem   [DEPTH];
   logic [XLEN-1:0]     mstatus_mem [DEPTH];
   logic                check_mem   [DEPTH];
   logic [XLEN-1:0]     cause_mem   [DEPTH];

   logic [PTR_W-1:0] head_q;
   logic [PTR_W-1:0] tail_q;
   logic [CNT_W-1:0] count_q;
   logic             overflow_q;

   logic [PTR_W-1:0] lane_slot [COMMIT_WIDTH];
   logic [PTR_W-1:0] trap_slot;
   logic [CNT_W-1:0] n_commit;
   logic [CNT_W-1:0] n_enq;
   logic [CNT_W-1:0] free_slots;
   logic             admit;
   logic             drop;
   logic             deq;

   // Compact valid lanes: each valid lane lands at tail plus the number of
   // valid lanes below it; the trap record follows the last commit.
   always_comb begin
      n_commit = '0;
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         lane_slot[i] = tail_q + n_commit[PTR_W-1:0];
         n_commit     = n_commit + CNT_W'(valid[i]);
      end
      trap_slot = tail_q + n_commit[PTR_W-1:0];
      n_enq     = n_commit + CNT_W'(int_xcpt);
   end

   // Admission is judged against start-of-cycle occupancy; a same-cycle
   // dequeue is deliberately not credited.
   always_comb begin
      free_slots = CNT_W'(DEPTH) - count_q;
      admit      = !reset && (n_enq != '0) && (n_enq <= free_slots);
      drop       = !reset && (n_enq > free_slots);
      deq        = !reset && out_valid && out_ready;
   end

   // Write the admitted batch into storage.
   always_ff @(posedge clock) begin
      if (admit) begin
         for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (valid[i]) begin
               is_trap_mem[lane_slot[i]] <= 1'b0;
               hartid_mem[lane_slot[i]]  <= hartid;
               pc_mem[lane_slot[i]]      <= pc[i*XLEN +: XLEN];
               inst_mem[lane_slot[i]]    <= inst[i*INST_LEN +: INST_LEN];
               wdata_mem[lane_slot[i]]   <= wdata[i*XLEN +: XLEN];
               mstatus_mem[lane_slot[i]] <= mstatus[i*XLEN +: XLEN];
               check_mem[lane_slot[i]]   <= check[i];
               cause_mem[lane_slot[i]]   <= '0;
            end
         end
         if (int_xcpt) begin
            is_trap_mem[trap_slot] <= 1'b1;
            hartid_mem[trap_slot]  <= hartid;
            pc_mem[trap_slot]      <= '0;
            inst_mem[trap_slot]    <= '0;
            wdata_mem[trap_slot]   <= '0;
            mstatus_mem[trap_slot] <= '0;
            check_mem[trap_slot]   <= 1'b0;
            cause_mem[trap_slot]   <= cause;
         end
      end
   end

   // Pointers, occupancy and the sticky overflow flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (admit) begin
            tail_q <= tail_q + n_enq[PTR_W-1:0];
         end
         if (deq) begin
            head_q <= head_q + 1'b1;
         end
         count_q <= count_q + (admit ? n_enq : '0) - CNT_W'(deq);
         if (drop) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // Head presentation and flags; stall depends on the count register only.
   always_comb begin
      out_valid   = (count_q != '0);
      out_is_trap = is_trap_mem[head_q];
      out_hartid  = hartid_mem[head_q];
      out_pc      = pc_mem[head_q];
      out_inst    = inst_mem[head_q];
      out_wdata   = wdata_mem[head_q];
      out_mstatus = mstatus_mem[head_q];
      out_check   = check_mem[head_q];
      out_cause   = cause_mem[head_q];
      stall       = (free_slots < CNT_W'(COMMIT_WIDTH + 1));
      overflow    = overflow_q;
      count       = count_q;
   end

endmodule

// File: tb/tb_cosim_trace_queue.sv
// Directed bench for cosim_trace_queue (COMMIT_WIDTH=3, XLEN=64, DEPTH=16).
module tb_cosim_trace_queue;

   localparam int CW = 3;
   localparam int XL = 64;
   localparam int IL = 32;
   localparam int DP = 16;

   logic            clock = 1'b0;
   logic            reset;
   logic [CW-1:0]   valid;
   logic [XL-1:0]   hartid;
   logic [XL*CW-1:0] pc;
   logic [IL*CW-1:0] inst;
   logic [XL*CW-1:0] wdata;
   logic [XL*CW-1:0] mstatus;
   logic [CW-1:0]   check;
   logic            int_xcpt;
   logic [XL-1:0]   cause;
   logic            out_valid;
   logic            out_ready;
   logic            out_is_trap;
   logic [XL-1:0]   out_hartid;
   logic [XL-1:0]   out_pc;
   logic [IL-1:0]   out_inst;
   logic [XL-1:0]   out_wdata;
   logic [XL-1:0]   out_mstatus;
   logic            out_check;
   logic [XL-1:0]   out_cause;
   logic            stall;
   logic            overflow;
   logic [4:0]      count;

   int n_cmp = 0;
   int n_bad = 0;

   cosim_trace_queue #(.COMMIT_WIDTH(CW), .XLEN(XL), .INST_LEN(IL), .DEPTH(DP)) dut (
      .clock(clock), .reset(reset), .valid(valid), .hartid(hartid), .pc(pc),
      .inst(inst), .wdata(wdata), .mstatus(mstatus), .check(check),
      .int_xcpt(int_xcpt), .cause(cause), .out_valid(out_valid),
      .out_ready(out_ready), .out_is_trap(out_is_trap), .out_hartid(out_hartid),
      .out_pc(out_pc), .out_inst(out_inst), .out_wdata(out_wdata),
      .out_mstatus(out_mstatus), .out_check(out_check), .out_cause(out_cause),
      .stall(stall), .overflow(overflow), .count(count)
   );

   always #5 clock = ~clock;

   // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      valid    = '0;
      int_xcpt = 1'b0;
      cause    = '0;
      pc       = '0;
      inst     = '0;
      wdata    = '0;
      mstatus  = '0;
      check    = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      out_ready = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   // Three-lane batch of sequential pcs starting at base.
   task automatic set_seq_lanes(input logic [XL-1:0] base, input logic [CW-1:0] v);
      valid = v;
      for (int l = 0; l < CW; l++) pc[l*XL +: XL] = base + XL'(4*l);
   endtask

   task automatic test_reset();
      hartid = 64'h5;
      do_reset();
      n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", count); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b want 0", stall); end
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got %b want 0", overflow); end
   endtask

   task automatic test_basic_order();
      out_ready = 1'b1;
      valid     = 3'b101;
      pc        = {64'h1008, 64'h1004, 64'h1000};
      inst      = {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
      wdata     = {64'hD2, 64'hD1, 64'hD0};
      mstatus   = {64'hA2, 64'hA1, 64'hA0};
      check     = 3'b100;
      int_xcpt  = 1'b1;
      cause     = 64'h8000_0000_0000_0007;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL no_bypass out_valid got %b want 0", out_valid); end
      step();
      idle_inputs();
      n_cmp++; if (count !== 5'd3) begin n_bad++; $display("FAIL basic_count got %0d want 3", count); end
      n_cmp++; if (out_pc !== 64'h1000 || out_is_trap !== 1'b0 || out_inst !== 32'hAAAA_0001)
         begin n_bad++; $display("FAIL basic_rec0 got pc=%h trap=%b inst=%h want pc=1000 trap=0 inst=aaaa0001", out_pc, out_is_trap, out_inst); end
      n_cmp++; if (out_wdata !== 64'hD0 || out_mstatus !== 64'hA0 || out_check !== 1'b0 || out_cause !== 64'h0 || out_hartid !== 64'h5)
         begin n_bad++; $display("FAIL basic_rec0_fields got wd=%h ms=%h ck=%b ca=%h hid=%h", out_wdata, out_mstatus, out_check, out_cause, out_hartid); end
      step();
      n_cmp++; if (out_pc !== 64'h1008 || out_wdata !== 64'hD2 || out_mstatus !== 64'hA2 || out_check !== 1'b1 || out_inst !== 32'hCCCC_0003)
         begin n_bad++; $display("FAIL basic_rec1 got pc=%h wd=%h ms=%h ck=%b inst=%h want pc=1008 wd=d2 ms=a2 ck=1 inst=cccc0003", out_pc, out_wdata, out_mstatus, out_check, out_inst); end
      step();
      n_cmp++; if (out_is_trap !== 1'b1 || out_cause !== 64'h8000_0000_0000_0007 || out_pc !== 64'h0 || out_wdata !== 64'h0 || out_check !== 1'b0 || out_inst !== 32'h0)
         begin n_bad++; $display("FAIL basic_trap got trap=%b cause=%h pc=%h wd=%h ck=%b inst=%h", out_is_trap, out_cause, out_pc, out_wdata, out_check, out_inst); end
      n_cmp++; if (count !== 5'd1) begin n_bad++; $display("FAIL basic_count_tail got %0d want 1", count); end
      step();
      n_cmp++; if (out_valid !== 1'b0 || count !== 5'd0) begin n_bad++; $display("FAIL basic_drained got valid=%b count=%0d want 0/0", out_valid, count); end
   endtask

   task automatic test_stall_fill();
      logic exp_stall;
      out_ready = 1'b0;
      for (int b = 0; b < 6; b++) begin
         if (!stall) set_seq_lanes(64'h2000 + 64'(12*b), 3'b111);
         else idle_inputs();
         step();
         idle_inputs();
         exp_stall = (b >= 4);
         n_cmp++; if (count !== 5'((b < 5) ? 3*(b+1) : 15))
            begin n_bad++; $display("FAIL fill_count batch %0d got %0d want %0d", b, count, (b < 5) ? 3*(b+1) : 15); end
         n_cmp++; if (stall !== exp_stall)
            begin n_bad++; $display("FAIL fill_stall batch %0d got %b want %b", b, stall, exp_stall); end
      end
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL fill_overflow got %b want 0", overflow); end
      out_ready = 1'b1;
      step();
      step();
      out_ready = 1'b0;
      n_cmp++; if (count !== 5'd13 || stall !== 1'b1) begin n_bad++; $display("FAIL fill_drain2 got count=%0d stall=%b want 13/1", count, stall); end
   endtask

   task automatic test_overflow();
      set_seq_lanes(64'h9000, 3'b111);
      int_xcpt = 1'b1;
      cause    = 64'h3;
      step();
      idle_inputs();
      n_cmp++; if (count !== 5'd13) begin n_bad++; $display("FAIL ovf_count got %0d want 13", count); end
      n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got %b want 1", overflow); end
      step();
      step();
      n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got %b want 1", overflow); end
      n_cmp++; if (out_pc !== 64'h2008) begin n_bad++; $display("FAIL ovf_head_stable got %h want 2008", out_pc); end
      do_reset();
      n_cmp++; if (overflow !== 1'b0 || count !== 5'd0) begin n_bad++; $display("FAIL ovf_cleared got ovf=%b count=%0d want 0/0", overflow, count); end
   endtask

   task automatic test_wrap_order();
      int sent = 0;
      int got  = 0;
      int n;
      for (int cyc = 0; cyc < 600 && got < 40; cyc++) begin
         out_ready = 1'($urandom_range(0, 1));
         if (out_valid && out_ready) begin
            n_cmp++;
            if (out_pc !== 64'h3000 + 64'(4*got) || out_is_trap !== 1'b0)
               begin n_bad++; $display("FAIL wrap_order idx %0d got pc=%h want %h", got, out_pc, 64'h3000 + 64'(4*got)); end
            got++;
         end
         idle_inputs();
         if (!stall && sent < 40) begin
            n = (40 - sent < CW) ? 40 - sent : CW;
            set_seq_lanes(64'h3000 + 64'(4*sent), CW'((1 << n) - 1));
            sent += n;
         end
         step();
      end
      idle_inputs();
      out_ready = 1'b0;
      n_cmp++; if (got !== 40) begin n_bad++; $display("FAIL wrap_timeout got %0d records want 40", got); end
      n_cmp++; if (count !== 5'd0 || overflow !== 1'b0) begin n_bad++; $display("FAIL wrap_end got count=%0d ovf=%b want 0/0", count, overflow); end
   endtask

   task automatic test_simul_enq_deq();
      out_ready = 1'b0;
      set_seq_lanes(64'h4000, 3'b111);
      step();
      set_seq_lanes(64'h400C, 3'b011);
      step();
      idle_inputs();
      n_cmp++; if (count !== 5'd5) begin n_bad++; $display("FAIL simul_pre got %0d want 5", count); end
      set_seq_lanes(64'h4014, 3'b011);
      out_ready = 1'b1;
      step();
      idle_inputs();
      out_ready = 1'b0;
      n_cmp++; if (count !== 5'd6) begin n_bad++; $display("FAIL simul_count got %0d want 6", count); end
      n_cmp++; if (out_pc !== 64'h4004) begin n_bad++; $display("FAIL simul_head got %h want 4004", out_pc); end
   endtask

   task automatic test_reset_mid_drain();
      do_reset();
      for (int b = 0; b < 3; b++) begin
         set_seq_lanes(64'h6000 + 64'(12*b), 3'b111);
         step();
      end
      idle_inputs();
      n_cmp++; if (count !== 5'd9) begin n_bad++; $display("FAIL mid_pre got %0d want 9", count); end
      out_ready = 1'b1;
      reset     = 1'b1;
      set_seq_lanes(64'h7000, 3'b111);
      int_xcpt  = 1'b1;
      step();
      n_cmp++; if (count !== 5'd0 || out_valid !== 1'b0)
         begin n_bad++; $display("FAIL mid_reset got count=%0d valid=%b want 0/0", count, out_valid); end
      step();
      n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL mid_reset_ignore got %0d want 0", count); end
      reset     = 1'b0;
      out_ready = 1'b0;
      idle_inputs();
      set_seq_lanes(64'h5000, 3'b001);
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_new_early got %b want 0", out_valid); end
      step();
      idle_inputs();
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 64'h5000 || count !== 5'd1)
         begin n_bad++; $display("FAIL mid_new got valid=%b pc=%h count=%0d want 1/5000/1", out_valid, out_pc, count); end
   endtask

   initial begin
      reset     = 1'b1;
      out_ready = 1'b0;
      hartid    = '0;
      idle_inputs();
      test_reset();
      test_basic_order();
      test_stall_fill();
      test_overflow();
      test_wrap_order();
      test_simul_enq_deq();
      test_reset_mid_drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cosim_trace_queue.md
# cosim_trace_queue

Parametrised commit/trap trace queue between the BOOM commit stage and the Dromajo co-simulation checker. Each cycle it captures up to COMMIT_WIDTH retired instructions plus an optional interrupt/exception event. It compacts them in program order into a DEPTH-entry FIFO and presents them one record per cycle on a valid/ready port. Unlike the direct per-cycle DPI stepping path, the checker may therefore run slower than commit. Back-pressure is signalled to the core through `stall`, and dropped batches are recorded in a sticky `overflow` flag.

## Interface
- COMMIT_WIDTH, 3, commit lanes per cycle (≥1)
- XLEN, 64, data/PC width
- INST_LEN, 32, instruction width
- DEPTH, 16, FIFO entries; power of two, ≥ COMMIT_WIDTH+1
- clock  in  1  sole clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- valid  in  COMMIT_WIDTH  per-lane commit valid
- hartid  in  XLEN  hart ID, sampled with every enqueued record
- pc  in  XLEN*COMMIT_WIDTH  lane i at bits [(i+1)*XLEN-1 -: XLEN]
- inst  in  INST_LEN*COMMIT_WIDTH  lane-packed the same way
- wdata, mstatus  in  XLEN*COMMIT_WIDTH  lane-packed
- check  in  COMMIT_WIDTH  per-lane "compare wdata" flag
- int_xcpt  in  1  trap/interrupt event this cycle
- cause  in  XLEN  trap cause
- out_valid  out  1  head record available
- out_ready  in  1  checker accepts head
- out_is_trap  out  1  head is a trap record
- out_hartid, out_pc, out_wdata, out_mstatus, out_cause  out  XLEN  head fields
- out_inst  out  INST_LEN  head instruction
- out_check  out  1  head check flag
- stall  out  1  fewer than COMMIT_WIDTH+1 free entries
- overflow  out  1  sticky: a batch was dropped
- count  out  $clog2(DEPTH+1)  current occupancy

## Operation
- Record = {is_trap, hartid, pc, inst, wdata, mstatus, check, cause}.
- Commit records: `cause` = 0, `is_trap` = 0.
- Trap records: pc/inst/wdata/mstatus/check = 0, `is_trap` = 1.
- Batch per cycle, when reset is low:
  - n_enq = popcount(valid) + int_xcpt.
  - Records are written in ascending lane order, skipping invalid lanes.
  - The trap record, if any, comes last in the batch.
  - Records occupy consecutive slots from the tail pointer, modulo DEPTH.
- Dequeue:
  - deq = out_valid && out_ready.
  - Head pointer advances by 1 modulo DEPTH.
- Admission uses occupancy at the start of the cycle, excluding the same-cycle dequeue.
  - If n_enq ≤ DEPTH − count, the whole batch is enqueued.
  - Otherwise the entire batch is dropped (no partial enqueue) and `overflow` sets to 1.
  - `overflow` holds until reset.
- Occupancy update: count' = count + (admitted ? n_enq : 0) − deq.
- Pointers are $clog2(DEPTH) bits and wrap naturally.
- out_valid = (count != 0). All out_* fields show the head entry. When out_valid = 0, out_* are don't-care.
- stall = (DEPTH − count) < COMMIT_WIDTH+1. It is combinational from the count register only; it does not depend on current-cycle inputs.
- The core is required to stop retiring while `stall` is high. Overflow therefore indicates a protocol violation, and the bench flags it.
- Reset behaviour:
  - Clears count, head, tail and overflow to 0. Entry storage is not cleared.
  - While reset is high, inputs are ignored and nothing is enqueued or dequeued.
  - Reset mid-drain discards all queued records.

## Timing
- Enqueue-to-visible latency is 1 cycle. A record written at edge N appears on out_* after edge N, when it is at the head.
- Throughput: up to COMMIT_WIDTH+1 in per cycle, 1 out per cycle.
- Head data stays stable while out_valid && !out_ready.
- On an empty queue, a same-cycle enqueue does not bypass to the output; out_valid rises the following cycle.
- Full queue with deq and n_enq > 0 in the same cycle: the batch is dropped. Admission does not credit the same-cycle dequeue.
- Outputs after reset: out_valid = 0, stall = 0, overflow = 0, count = 0.

## Test plan
- Reset, then valid=3'b101 with pc lanes 0x1000/0x1004/0x1008, int_xcpt=1, cause=0x8000000000000007, out_ready=1 → count goes to 3; output sequence over three cycles is pc 0x1000, then pc 0x1008, then a trap record with cause 0x8000000000000007.
- out_ready=0, with valid=3'b111 every cycle (DEPTH=16, CW=3) → stall rises when count reaches 13, i.e. after 5 batches with count=15; no overflow while the core honours stall.
- Force a batch of 4 records with count=13 → batch dropped, count stays 13, overflow=1 and stays 1 until reset.
- Fill with 40 sequential PCs under random out_ready → output PCs strictly in order across pointer wrap, with no duplicates or losses.
- Simultaneous enqueue of 2 records and dequeue at count=5 → count=6 on the next cycle.
- Assert reset with count=9 mid-drain → next cycle count=0, out_valid=0; a new commit after deassertion appears 1 cycle later.
